riscv_test_sequencer: RTL and testbench

RISCV_TEST_SEQUENCER -- requirements
Module: riscv_test_sequencer

---
 rtl/riscv_test_sequencer.sv | 170 +++++++++++++++++
 tb/tb_riscv_test_sequencer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_test_sequencer.sv
// ============================================================================
//  Module      : riscv_test_sequencer
//  Description : Resets, runs and freezes a RISC-V core, then checks a list
//                of register/value pairs through the core's register file.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module riscv_test_sequencer #(
    parameter int XLEN         = 32,
    parameter int NUM_CHECKS   = 1,
    parameter int RESET_CYCLES = 2,
    parameter int RUN_CYCLES   = 376,
    parameter int MODE         = 0,
    parameter int HALT_STABLE  = 4
) (
    input  logic                       clock,
    input  logic                       rst,
    input  logic                       start,
    input  logic [XLEN-1:0]            pc,
    input  logic [XLEN-1:0]            rf_rd_data,
    input  logic [5*NUM_CHECKS-1:0]    chk_addr,
    input  logic [XLEN*NUM_CHECKS-1:0] chk_value,
    output logic                       core_rstn,
    output logic                       core_hold,
    output logic [4:0]                 rf_rd_addr,
    output logic                       busy,
    output logic                       done,
    output logic                       pass,
    output logic                       timeout,
    output logic [4:0]                 fail_index,
    output logic [31:0]                cycle_count
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RESET = 3'd1,
        S_RUN   = 3'd2,
        S_CHECK = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [31:0] c_RST_LAST  = 32'(RESET_CYCLES - 1);
    localparam logic [31:0] c_RUN_LIMIT = 32'(RUN_CYCLES);
    localparam logic [31:0] c_HALT_CNT  = 32'(HALT_STABLE);
    localparam logic [4:0]  c_LAST_IDX  = 5'(NUM_CHECKS - 1);

    state_t          r_state;
    logic [4:0]      r_index;
    logic [31:0]     r_rst_cnt;
    logic [31:0]     r_stable;
    logic [XLEN-1:0] r_pc_prev;

    // Check list padded to 32 entries so a 5-bit index selects it exactly
    logic [4:0]      w_addr_tab [32];
    logic [XLEN-1:0] w_val_tab  [32];

    for (genvar gi = 0; gi < 32; gi++) begin : g_tab
        if (gi < NUM_CHECKS) begin : g_used
            assign w_addr_tab[gi] = chk_addr[5*gi +: 5];
            assign w_val_tab[gi]  = chk_value[XLEN*gi +: XLEN];
        end else begin : g_unused
            assign w_addr_tab[gi] = '0;
            assign w_val_tab[gi]  = '0;
        end
    end

    logic [31:0] w_stable_next;
    logic        w_halt;
    logic        w_budget;
    logic        w_match;

    assign w_stable_next = (pc != r_pc_prev)        ? 32'd0    :
                           (r_stable == 32'hFFFF_FFFF) ? r_stable : r_stable + 32'd1;
    assign w_halt        = (MODE == 1) && (w_stable_next >= c_HALT_CNT);
    assign w_budget      = (cycle_count == c_RUN_LIMIT);
    assign w_match       = (rf_rd_data == w_val_tab[r_index]);

    // Register-file read is asynchronous, so the address follows the index directly
    assign rf_rd_addr = (r_state == S_CHECK) ? w_addr_tab[r_index] : 5'd0;

    // {core_rstn, core_hold, busy, done} for the state being entered
    function automatic logic [3:0] f_outs(input state_t s);
        case (s)
            S_RESET: f_outs = 4'b0010;
            S_RUN:   f_outs = 4'b1010;
            S_CHECK: f_outs = 4'b1110;
            S_DONE:  f_outs = 4'b1101;
            default: f_outs = 4'b0100;
        endcase
    endfunction

    always_ff @(posedge clock) begin
        if (rst) begin
            r_state     <= S_IDLE;
            {core_rstn, core_hold, busy, done} <= f_outs(S_IDLE);
            pass        <= 1'b0;
            timeout     <= 1'b0;
            fail_index  <= 5'd0;
            cycle_count <= 32'd0;
            r_index     <= 5'd0;
            r_rst_cnt   <= 32'd0;
            r_stable    <= 32'd0;
            r_pc_prev   <= '0;
        end else begin
            r_pc_prev <= pc;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state     <= S_RESET;
                        {core_rstn, core_hold, busy, done} <= f_outs(S_RESET);
                        pass        <= 1'b0;
                        timeout     <= 1'b0;
                        fail_index  <= 5'd0;
                        cycle_count <= 32'd0;
                        r_rst_cnt   <= 32'd0;
                    end
                end
                S_RESET: begin
                    if (r_rst_cnt == c_RST_LAST) begin
                        r_state     <= S_RUN;
                        {core_rstn, core_hold, busy, done} <= f_outs(S_RUN);
                        cycle_count <= 32'd1;
                        r_stable    <= 32'd0;
                    end else begin
                        r_rst_cnt <= r_rst_cnt + 32'd1;
                    end
                end
                S_RUN: begin
                    r_stable <= w_stable_next;
                    // Halt wins over a budget that runs out in the same cycle
                    if (w_halt || (MODE == 0 && w_budget)) begin
                        r_state <= S_CHECK;
                        {core_rstn, core_hold, busy, done} <= f_outs(S_CHECK);
                        r_index <= 5'd0;
                    end else if (w_budget) begin
                        r_state <= S_DONE;
                        {core_rstn, core_hold, busy, done} <= f_outs(S_DONE);
                        timeout <= 1'b1;
                        pass    <= 1'b0;
                    end else if (cycle_count != 32'hFFFF_FFFF) begin
                        cycle_count <= cycle_count + 32'd1;
                    end
                end
                S_CHECK: begin
                    if (!w_match) begin
                        r_state    <= S_DONE;
                        {core_rstn, core_hold, busy, done} <= f_outs(S_DONE);
                        fail_index <= r_index;
                        pass       <= 1'b0;
                    end else if (r_index == c_LAST_IDX) begin
                        r_state    <= S_DONE;
                        {core_rstn, core_hold, busy, done} <= f_outs(S_DONE);
                        fail_index <= 5'd0;
                        pass       <= 1'b1;
                    end else begin
                        r_index <= r_index + 5'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    {core_rstn, core_hold, busy, done} <= f_outs(S_IDLE);
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_riscv_test_sequencer.sv
// ============================================================================
//  Module      : tb_riscv_test_sequencer
//  Description : Scoreboard bench for riscv_test_sequencer with small core models.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_riscv_test_sequencer;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        rst;
    logic [3:0]  start_v;
    logic [3:0]  core_rstn_v, core_hold_v, busy_v, done_v, pass_v, timeout_v;
    logic [4:0]  rf_addr_v [4];
    logic [4:0]  fi_v      [4];
    logic [31:0] cc_v      [4];
    logic [31:0] rf_data_v [4];
    logic [31:0] pc_v      [4];
    logic [31:0] chk_val0;
    logic [95:0] chk_val3;

    // Index 0: defaults (Fibonacci), 1: three checks, 2: halt-detect, 3: halt-detect timeout
    riscv_test_sequencer u_d0 (
        .clock(clock), .rst(rst), .start(start_v[0]), .pc(pc_v[0]), .rf_rd_data(rf_data_v[0]),
        .chk_addr(5'd10), .chk_value(chk_val0),
        .core_rstn(core_rstn_v[0]), .core_hold(core_hold_v[0]), .rf_rd_addr(rf_addr_v[0]),
        .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]), .timeout(timeout_v[0]),
        .fail_index(fi_v[0]), .cycle_count(cc_v[0]));

    riscv_test_sequencer #(.NUM_CHECKS(3), .RUN_CYCLES(20)) u_d3 (
        .clock(clock), .rst(rst), .start(start_v[1]), .pc(pc_v[1]), .rf_rd_data(rf_data_v[1]),
        .chk_addr({5'd5, 5'd3, 5'd2}), .chk_value(chk_val3),
        .core_rstn(core_rstn_v[1]), .core_hold(core_hold_v[1]), .rf_rd_addr(rf_addr_v[1]),
        .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]), .timeout(timeout_v[1]),
        .fail_index(fi_v[1]), .cycle_count(cc_v[1]));

    riscv_test_sequencer #(.MODE(1), .HALT_STABLE(4), .RUN_CYCLES(204)) u_m1 (
        .clock(clock), .rst(rst), .start(start_v[2]), .pc(pc_v[2]), .rf_rd_data(rf_data_v[2]),
        .chk_addr(5'd10), .chk_value(32'h0000_0037),
        .core_rstn(core_rstn_v[2]), .core_hold(core_hold_v[2]), .rf_rd_addr(rf_addr_v[2]),
        .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]), .timeout(timeout_v[2]),
        .fail_index(fi_v[2]), .cycle_count(cc_v[2]));

    riscv_test_sequencer #(.MODE(1), .HALT_STABLE(4), .RUN_CYCLES(50)) u_t1 (
        .clock(clock), .rst(rst), .start(start_v[3]), .pc(pc_v[3]), .rf_rd_data(rf_data_v[3]),
        .chk_addr(5'd0), .chk_value(32'h0000_0000),
        .core_rstn(core_rstn_v[3]), .core_hold(core_hold_v[3]), .rf_rd_addr(rf_addr_v[3]),
        .busy(busy_v[3]), .done(done_v[3]), .pass(pass_v[3]), .timeout(timeout_v[3]),
        .fail_index(fi_v[3]), .cycle_count(cc_v[3]));

    // Fibonacci core: x10 reaches fib(47) = 2971215073 after 47 running cycles
    logic [31:0] fa = 32'd0, fb = 32'd1, hpc = 32'd0, fpc = 32'd0;
    int          fn = 0;
    always @(posedge clock) begin
        if (!core_rstn_v[0]) begin
            fa <= 32'd0; fb <= 32'd1; fn <= 0;
        end else if (!core_hold_v[0] && fn < 47) begin
            fa <= fb; fb <= fa + fb; fn <= fn + 1;
        end
        // PC at RUN cycle k is 4*(k-1), parking on a self-jump from cycle 200
        if (!core_rstn_v[2])                          hpc <= 32'd0;
        else if (!core_hold_v[2] && hpc != 32'd796)   hpc <= hpc + 32'd4;
        if (!core_rstn_v[3])                          fpc <= 32'd0;
        else if (!core_hold_v[3])                     fpc <= fpc + 32'd4;
    end

    always_comb begin
        pc_v[0]      = 32'd0;
        pc_v[1]      = 32'd0;
        pc_v[2]      = hpc;
        pc_v[3]      = fpc;
        rf_data_v[0] = (rf_addr_v[0] == 5'd10) ? fa : 32'hDEAD_BEEF;
        case (rf_addr_v[1])
            5'd2:    rf_data_v[1] = 32'h11;
            5'd3:    rf_data_v[1] = 32'h22;
            5'd5:    rf_data_v[1] = 32'h55;
            default: rf_data_v[1] = 32'h0;
        endcase
        rf_data_v[2] = (rf_addr_v[2] == 5'd10) ? 32'h37 : 32'h0;
        rf_data_v[3] = 32'h0;
    end

    typedef struct {
        int          id;
        logic        pass;
        logic        to;
        logic [4:0]  fi;
        logic [31:0] cc;
        int          rc;
        int          runc;
        int          chkc;
    } exp_t;

    exp_t exp_q[$];
    exp_t e_m;
    int   vectors = 0;
    int   miscompares = 0;

    task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic push(input int id, input logic p, input logic to, input logic [4:0] fi,
                        input logic [31:0] cc, input int rc, input int runc, input int chkc);
        exp_t e;
        e.id = id; e.pass = p; e.to = to; e.fi = fi; e.cc = cc;
        e.rc = rc; e.runc = runc; e.chkc = chkc;
        exp_q.push_back(e);
    endtask

    // Monitor: counts phase lengths per DUT and scores each rising done
    int         rc[4];
    int         runc[4];
    int         chkc[4];
    logic [3:0] done_d = 4'b0;
    initial begin
        for (int d = 0; d < 4; d++) begin rc[d] = 0; runc[d] = 0; chkc[d] = 0; end
        forever begin
            @(negedge clock);
            for (int d = 0; d < 4; d++) begin
                if (busy_v[d]) begin
                    if (!core_rstn_v[d])      rc[d]++;
                    else if (!core_hold_v[d]) runc[d]++;
                    else                      chkc[d]++;
                end
                if (done_v[d] && !done_d[d]) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_done", 64'(d), 64'hFF);
                    end else begin
                        e_m = exp_q.pop_front();
                        chk("dut_id",       64'(d),            64'(e_m.id));
                        chk("pass",         64'(pass_v[d]),    64'(e_m.pass));
                        chk("timeout",      64'(timeout_v[d]), 64'(e_m.to));
                        chk("fail_index",   64'(fi_v[d]),      64'(e_m.fi));
                        chk("cycle_count",  64'(cc_v[d]),      64'(e_m.cc));
                        chk("reset_cycles", 64'(rc[d]),        64'(e_m.rc));
                        chk("run_cycles",   64'(runc[d]),      64'(e_m.runc));
                        chk("check_cycles", 64'(chkc[d]),      64'(e_m.chkc));
                        chk("done_rf_addr", 64'(rf_addr_v[d]), 64'd0);
                    end
                end
                if (!busy_v[d]) begin rc[d] = 0; runc[d] = 0; chkc[d] = 0; end
            end
            done_d = done_v;
        end
    end

    task automatic pulse_start(input int d);
        @(posedge clock); #1 start_v[d] = 1'b1;
        @(posedge clock); #1 start_v[d] = 1'b0;
    endtask

    task automatic wait_done(input int d, input int budget);
        int n = 0;
        while (!done_v[d] && n < budget) begin
            @(negedge clock);
            n++;
        end
        chk("done_reached", 64'(done_v[d]), 64'd1);
    endtask

    task automatic check_reset_state(input int d);
        chk("reset_state",
            {core_rstn_v[d], core_hold_v[d], busy_v[d], done_v[d], pass_v[d], timeout_v[d],
             fi_v[d], cc_v[d], rf_addr_v[d]},
            {1'b0, 1'b1, 4'b0000, 5'd0, 32'd0, 5'd0});
    endtask

    initial begin
        int n;
        rst      = 1'b1;
        start_v  = 4'b0;
        chk_val0 = 32'd2971215073;
        chk_val3 = {32'h55, 32'h23, 32'h11};
        repeat (3) @(posedge clock);
        @(negedge clock);
        for (int d = 0; d < 4; d++) check_reset_state(d);
        @(posedge clock); #1 rst = 1'b0;

        // Fibonacci pass
        push(0, 1'b1, 1'b0, 5'd0, 32'd376, 2, 376, 1);
        pulse_start(0);
        wait_done(0, 600);

        // Restart from DONE with a wrong value; start while busy is ignored
        chk_val0 = 32'd2971215072;
        push(0, 1'b0, 1'b0, 5'd0, 32'd376, 2, 376, 1);
        pulse_start(0);
        @(negedge clock);
        chk("restart_state", {pass_v[0], busy_v[0], done_v[0]}, 3'b010);
        repeat (50) @(posedge clock);
        #1 start_v[0] = 1'b1;
        @(posedge clock); #1 start_v[0] = 1'b0;
        wait_done(0, 600);

        // Reset at RUN cycle 100, then reset beating start
        chk_val0 = 32'd2971215073;
        pulse_start(0);
        n = 0;
        while (cc_v[0] != 32'd100 && n < 300) begin @(negedge clock); n++; end
        chk("reached_run_100", 64'(cc_v[0]), 64'd100);
        rst = 1'b1;
        @(negedge clock);
        check_reset_state(0);
        start_v[0] = 1'b1;
        @(negedge clock);
        chk("rst_beats_start", {busy_v[0], core_rstn_v[0], core_hold_v[0]}, 3'b001);
        rst = 1'b0;
        start_v[0] = 1'b0;

        push(0, 1'b1, 1'b0, 5'd0, 32'd376, 2, 376, 1);
        pulse_start(0);
        wait_done(0, 600);

        // Three checks: middle entry wrong, all correct, first entry wrong
        push(1, 1'b0, 1'b0, 5'd1, 32'd20, 2, 20, 2);
        pulse_start(1);
        wait_done(1, 100);
        chk_val3 = {32'h55, 32'h22, 32'h11};
        push(1, 1'b1, 1'b0, 5'd0, 32'd20, 2, 20, 3);
        pulse_start(1);
        wait_done(1, 100);
        chk_val3 = {32'h55, 32'h22, 32'h10};
        push(1, 1'b0, 1'b0, 5'd0, 32'd20, 2, 20, 1);
        pulse_start(1);
        wait_done(1, 100);

        // Halt detected exactly as the budget runs out
        push(2, 1'b1, 1'b0, 5'd0, 32'd204, 2, 204, 1);
        pulse_start(2);
        wait_done(2, 400);

        // Non-halting program times out
        push(3, 1'b0, 1'b1, 5'd0, 32'd50, 2, 50, 0);
        pulse_start(3);
        wait_done(3, 200);

        repeat (3) @(negedge clock);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
